// File: rtl/uart_rs232_tx.sv
// RS-232 UART transmitter: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an external oversampling Tick; define UART_TX_PARITY_EN to add the parity bit.
module uart_rs232_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       TxEn,
  input  logic       TxStart,
  input  logic [7:0] TxData,
  input  logic [3:0] NBits,
`ifdef UART_TX_PARITY_EN
  input  logic       ParityOdd,
`endif
  output logic       Tx,
  output logic       Busy,
  output logic       TxDone
);

  localparam int TW = ($clog2(OVERSAMPLE) > 4) ? $clog2(OVERSAMPLE) : 4;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;       // data bit index, reused as stop bit index
  logic [2:0]    last_q, last_d;     // index of the last data bit (NBits-1)
  logic [7:0]    shreg_q, shreg_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       bit_end;
  logic [3:0] nb_m1;
  logic [2:0] nb_last;

  assign bit_end = Tick && (tick_q == TICK_LAST);
  assign nb_m1   = NBits - 4'd1;
  // Out-of-range widths fall back to a full byte.
  assign nb_last = (NBits >= 4'd5 && NBits <= 4'd8) ? nb_m1[2:0] : 3'd7;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      last_q  <= 3'd7;
      shreg_q <= '0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch can be inferred.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE && Tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (TxEn && TxStart) begin
          state_d = S_START;
          tick_d  = '0;
          bit_d   = '0;
          last_d  = nb_last;
          shreg_d = TxData;
`ifdef UART_TX_PARITY_EN
          par_d   = (^(TxData & (8'hFF >> (3'd7 - nb_last)))) ^ ParityOdd;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == last_q) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tx decodes straight from state so an async reset forces the line high immediately.
  always_comb begin
    Tx = 1'b1;
    unique case (state_q)
      S_START:  Tx = 1'b0;
      S_DATA:   Tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: Tx = par_q;
`endif
      default:  Tx = 1'b1;
    endcase
    Busy   = (state_q != S_IDLE);
    TxDone = done_q;
  end

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Self-checking bench for uart_rs232_tx: two instances (1 and 2 stop bits) on shared stimulus,
// compared every cycle against a frame-level model, plus hand-computed frame expectations.
module tb_uart_rs232_tx;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       Clk, Rst_n, Tick, TxEn, TxStart, par_odd;
  logic [7:0] TxData;
  logic [3:0] NBits;
  logic [1:0] tx_w, busy_w, done_w;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  uart_rs232_tx #(.OVERSAMPLE(OS), .STOP_BITS(1)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .TxEn(TxEn), .TxStart(TxStart),
    .TxData(TxData), .NBits(NBits),
`ifdef UART_TX_PARITY_EN
    .ParityOdd(par_odd),
`endif
    .Tx(tx_w[0]), .Busy(busy_w[0]), .TxDone(done_w[0])
  );

  uart_rs232_tx #(.OVERSAMPLE(OS), .STOP_BITS(2)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .TxEn(TxEn), .TxStart(TxStart),
    .TxData(TxData), .NBits(NBits),
`ifdef UART_TX_PARITY_EN
    .ParityOdd(par_odd),
`endif
    .Tx(tx_w[1]), .Busy(busy_w[1]), .TxDone(done_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int norm_nb(input logic [3:0] nb);
    return (nb >= 4'd5 && nb <= 4'd8) ? int'(nb) : 8;
  endfunction

  // Line level for each bit period of the frame, index 0 = start bit; unused tail stays high.
  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic [3:0] nb, input logic odd);
    logic [15:0] f;
    logic        p;
    int          n;
    n = norm_nb(nb);
    f = '1;
    f[0] = 1'b0;
    p = odd;
    for (int i = 0; i < n; i++) begin
      f[i+1] = d[i];
      p = p ^ d[i];
    end
    if (P == 1) f[n+1] = p;
    return f;
  endfunction

  logic [15:0] m_frame [2];
  int          m_ticks [2];
  int          m_total [2];
  logic        m_busy  [2];
  logic        m_done  [2];

  always @(posedge Clk or negedge Rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!Rst_n) begin
        m_busy[u]  <= 1'b0;
        m_done[u]  <= 1'b0;
        m_ticks[u] <= 0;
      end else begin
        m_done[u] <= 1'b0;
        if (m_busy[u]) begin
          if (Tick) begin
            m_ticks[u] <= m_ticks[u] + 1;
            if (m_ticks[u] == m_total[u] - 1) begin
              m_busy[u] <= 1'b0;
              m_done[u] <= 1'b1;
            end
          end
        end else if (TxEn && TxStart) begin
          m_busy[u]  <= 1'b1;
          m_ticks[u] <= 0;
          m_frame[u] <= build_frame(TxData, NBits, par_odd);
          m_total[u] <= (1 + norm_nb(NBits) + P + (u + 1)) * OS;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        for (int u = 0; u < 2; u++) begin
          check($sformatf("tx_u%0d", u), 32'(tx_w[u]),
                32'(m_busy[u] ? m_frame[u][4'(m_ticks[u] / OS)] : 1'b1));
          check($sformatf("busy_u%0d", u), 32'(busy_w[u]), 32'(m_busy[u]));
          check($sformatf("done_u%0d", u), 32'(done_w[u]), 32'(m_done[u]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (done_w[0]) done_cnt++;
    end
  end

  // Tick: one pulse every third Clk, so most cycles carry no Tick.
  initial begin
    Tick = 1'b0;
    forever begin
      for (int k = 0; k < 3; k++) begin
        @(posedge Clk);
        #2;
        Tick = (k == 2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic request(input logic [7:0] d, input logic [3:0] nb);
    @(posedge Clk); #2;
    TxData = d; NBits = nb; TxStart = 1'b1; TxEn = 1'b1;
    @(posedge Clk); #2;
    TxStart = 1'b0; TxData = 8'h00; NBits = 4'd2;
  endtask

  // Counts Ticks from the accept edge to TxDone and records Tx mid-bit for each bit period.
  task automatic measure(input int u, output int ticks, output logic [15:0] mids, output logic seen);
    ticks = 0; mids = '1; seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge Clk);
      if (done_w[u]) begin
        seen = 1'b1;
      end else if (Tick) begin
        if (ticks % OS == OS / 2) mids[4'(ticks / OS)] = tx_w[u];
        ticks++;
      end
    end
    check($sformatf("done_seen_u%0d", u), 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge Clk);
      ok = (busy_w == 2'b00);
    end
    check("idle_wait", 32'(ok), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int          ticks;
    logic [15:0] mids;
    logic        seen;
    int          d0;

    Rst_n = 1'b0; TxEn = 1'b0; TxStart = 1'b0; TxData = '0; NBits = 4'd8; par_odd = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_tx", 32'(tx_w), 32'h3);
    check("reset_busy", 32'(busy_w), 32'h0);
    check("reset_done", 32'(done_w), 32'h0);
    @(posedge Clk); #2;
    Rst_n = 1'b1;

    // 1: A5, 8 bits, 160 Ticks
    request(8'hA5, 4'd8);
    measure(0, ticks, mids, seen);
    check("a5_ticks", 32'(ticks), 32'(160 + P * OS));
    check("a5_bits", 32'(mids[9:0]), 32'b11_0100_1010);
    wait_idle();

    // 2: FF with 7, 6, and out-of-range 4 data bits
    request(8'hFF, 4'd7);
    measure(0, ticks, mids, seen);
    check("n7_ticks", 32'(ticks), 32'(144 + P * OS));
    check("n7_bits", 32'(mids[7:0]), 32'hFE);
    wait_idle();
    request(8'hFF, 4'd6);
    measure(0, ticks, mids, seen);
    check("n6_ticks", 32'(ticks), 32'(128 + P * OS));
    wait_idle();
    request(8'hFF, 4'd4);
    measure(0, ticks, mids, seen);
    check("n4_ticks", 32'(ticks), 32'(160 + P * OS));
    check("n4_bits", 32'(mids[8:0]), 32'h1FE);
    wait_idle();

    // 3: back-to-back request in the TxDone cycle, ignored requests while busy
    d0 = done_cnt;
    request(8'h81, 4'd8);
    measure(0, ticks, mids, seen);
    TxData = 8'h3C; NBits = 4'd8; TxStart = 1'b1;
    check("b2b_done_cycle_tx", 32'(tx_w[0]), 32'd1);
    @(posedge Clk); #2;
    TxStart = 1'b0; TxData = 8'hFF;
    check("b2b_start_tx", 32'(tx_w[0]), 32'd0);
    check("b2b_start_busy", 32'(busy_w[0]), 32'd1);
    fork
      measure(0, ticks, mids, seen);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (50) @(posedge Clk);
          #2; TxStart = 1'b1;
          @(posedge Clk); #2; TxStart = 1'b0;
        end
      end
    join
    check("b2b_ticks", 32'(ticks), 32'(160 + P * OS));
    check("b2b_bits", 32'(mids[9:0]), 32'b10_0111_1000);
    repeat (600) @(posedge Clk);
    check("b2b_frames", 32'(done_cnt - d0), 32'd2);

    // 4: reset during the 4th data bit
    request(8'hA5, 4'd8);
    repeat (215) @(posedge Clk);
    #2; Rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx_w), 32'h3);
    check("rst_mid_busy", 32'(busy_w), 32'h0);
    d0 = done_cnt;
    @(posedge Clk); #2; Rst_n = 1'b1;
    repeat (40) @(posedge Clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    request(8'hA5, 4'd8);
    measure(0, ticks, mids, seen);
    check("rst_after_ticks", 32'(ticks), 32'(160 + P * OS));
    check("rst_after_bits", 32'(mids[9:0]), 32'b11_0100_1010);
    wait_idle();

    // 5: TxEn low refuses requests; dropping it mid-frame lets the frame finish
    @(posedge Clk); #2;
    TxEn = 1'b0; TxStart = 1'b1; TxData = 8'h55;
    repeat (30) @(posedge Clk);
    #1;
    check("en_off_busy", 32'(busy_w), 32'h0);
    check("en_off_tx", 32'(tx_w), 32'h3);
    #1; TxStart = 1'b0;
    request(8'h5A, 4'd8);
    fork
      measure(0, ticks, mids, seen);
      begin repeat (100) @(posedge Clk); #2; TxEn = 1'b0; end
    join
    check("en_drop_ticks", 32'(ticks), 32'(160 + P * OS));
    check("en_drop_bits", 32'(mids[9:0]), 32'b10_1011_0100);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 6a: parity of 8'h07 (three ones)
    par_odd = 1'b0;
    request(8'h07, 4'd8);
    measure(0, ticks, mids, seen);
    check("par_even", 32'(mids[9]), 32'd1);
    wait_idle();
    par_odd = 1'b1;
    request(8'h07, 4'd8);
    measure(0, ticks, mids, seen);
    check("par_odd", 32'(mids[9]), 32'd0);
    wait_idle();
    par_odd = 1'b0;
`endif

    // 6b: two stop bits on the second instance
    request(8'h07, 4'd8);
    measure(1, ticks, mids, seen);
    check("stop2_ticks", 32'(ticks), 32'((11 + P) * OS));
    check("stop2_high", 32'({mids[10+P], mids[9+P]}), 32'h3);
    check("stop2_data", 32'(mids[8:1]), 32'h07);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
